// File: rtl/demux_1para8_8bits_reg_pkg.sv
// rtl/demux_1para8_8bits_reg_pkg.sv - shared constants, FSM encoding and occupancy helper
package demux_1para8_8bits_reg_pkg;

  localparam int N_SAIDAS = 8;

  typedef enum logic [1:0] {
    VAZIO   = 2'd0,
    PARCIAL = 2'd1,
    CHEIO   = 2'd2
  } estado_t;

  // Occupancy class of a valid mask: none, some, or all registers written.
  function automatic estado_t estado_de(input logic [N_SAIDAS-1:0] v);
    if (v == '0)
      return VAZIO;
    else if (&v)
      return CHEIO;
    else
      return PARCIAL;
  endfunction

endpackage

// File: rtl/demux_1para8_8bits_reg_if.sv
// rtl/demux_1para8_8bits_reg_if.sv - write request and holding-register bank bundle
interface demux_1para8_8bits_reg_if
  import demux_1para8_8bits_reg_pkg::*;
#(
  parameter int W = 8
);

  logic [W-1:0]        din;
  logic [2:0]          sel;
  logic                wr_en;
  logic                auto_mode;
  logic                clr;

  logic [W-1:0]        out0;
  logic [W-1:0]        out1;
  logic [W-1:0]        out2;
  logic [W-1:0]        out3;
  logic [W-1:0]        out4;
  logic [W-1:0]        out5;
  logic [W-1:0]        out6;
  logic [W-1:0]        out7;
  logic [N_SAIDAS-1:0] valid;
  logic [2:0]          ptr;
  logic                ack;
  logic [2:0]          ack_idx;
  logic                full;
  logic                ovf;

  modport master (
    output din, sel, wr_en, auto_mode, clr,
    input  out0, out1, out2, out3, out4, out5, out6, out7,
    input  valid, ptr, ack, ack_idx, full, ovf
  );

  modport slave (
    input  din, sel, wr_en, auto_mode, clr,
    output out0, out1, out2, out3, out4, out5, out6, out7,
    output valid, ptr, ack, ack_idx, full, ovf
  );

endinterface

// File: rtl/demux_1para8_8bits_reg_decodificador_3x8.sv
// rtl/demux_1para8_8bits_reg_decodificador_3x8.sv - gated one-hot decoder for register load enables
module decodificador_3x8
  import demux_1para8_8bits_reg_pkg::*;
(
  input  logic [2:0]          idx,
  input  logic                en,
  output logic [N_SAIDAS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en)
      onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/demux_1para8_8bits_reg.sv
// rtl/demux_1para8_8bits_reg.sv - registered 1-to-8 demux with auto-increment scatter and occupancy FSM
module demux_1para8_8bits_reg
  import demux_1para8_8bits_reg_pkg::*;
#(
  parameter int W = 8
)(
  input  logic               clk,
  input  logic               rst,
  demux_1para8_8bits_reg_if.slave bus
);

  logic [W-1:0]        regs [N_SAIDAS];
  logic [N_SAIDAS-1:0] valid_q;
  logic [2:0]          ptr_q;
  logic [2:0]          idx_q;
  logic                ack_q;
  logic                ovf_q;
  logic                full;
  estado_t             estado;
  estado_t             estado_prox;

  logic [2:0]          d;
  logic                aceita;
  logic [N_SAIDAS-1:0] carga;

  assign d      = bus.auto_mode ? ptr_q : bus.sel;
  // Auto mode refuses to write into a full bank; direct mode may always overwrite.
  assign aceita = bus.wr_en && !bus.clr && !(bus.auto_mode && full);

  decodificador_3x8 u_dec (
    .idx    (d),
    .en     (aceita),
    .onehot (carga)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      for (int i = 0; i < N_SAIDAS; i++)
        regs[i] <= '0;
      valid_q <= '0;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_SAIDAS; i++)
        if (carga[i])
          regs[i] <= bus.din;
      valid_q <= valid_q | carga;
      ack_q   <= aceita;
      if (aceita)
        idx_q <= d;
      if (aceita && bus.auto_mode)
        ptr_q <= ptr_q + 3'd1;
      if (bus.wr_en && bus.auto_mode && full)
        ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      estado <= VAZIO;
    else
      estado <= estado_prox;
  end

  // Next state follows the valid mask as it will be after this edge.
  always_comb begin
    estado_prox = estado;
    if (bus.clr)
      estado_prox = VAZIO;
    else
      estado_prox = estado_de(valid_q | carga);
  end

  always_comb begin
    full = 1'b0;
    if (estado == CHEIO)
      full = 1'b1;
  end

  assign bus.out0    = regs[0];
  assign bus.out1    = regs[1];
  assign bus.out2    = regs[2];
  assign bus.out3    = regs[3];
  assign bus.out4    = regs[4];
  assign bus.out5    = regs[5];
  assign bus.out6    = regs[6];
  assign bus.out7    = regs[7];
  assign bus.valid   = valid_q;
  assign bus.ptr     = ptr_q;
  assign bus.ack     = ack_q;
  assign bus.ack_idx = idx_q;
  assign bus.full    = full;
  assign bus.ovf     = ovf_q;

endmodule
